// File: rtl/rr_arbiter_weighted.sv
// Weighted round-robin arbiter: one registered one-hot grant, held until ack or abort.
// Latency: request to grant 1 cycle; after each release the grant drops for at least one cycle.
// Backpressure: a granted requester keeps the grant until it acks or drops its request.
//
// Ports:
//   clk        rising-edge clock
//   rst_an     asynchronous active-low reset
//   req[N]     request, one bit per requester
//   ack[N]     completion; only the bit of the granted requester is honoured
//   weight     N fields of CW bits; field value w allows w+1 consecutive grants
//   grant[N]   registered one-hot grant, zero when idle
//   grant_idx  binary index of the granted requester, zero when idle
//   busy       high exactly when grant is non-zero
module rr_arbiter_weighted #(
  parameter int N  = 4,
  parameter int CW = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    ack,
  input  logic [N*CW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_idx,
  output logic            busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;     // highest-priority requester
  logic [CW-1:0]   cnt_q, cnt_d;     // consecutive grants already used by ptr
  logic [IW-1:0]   idx_q, idx_d;     // granted index
  logic [N-1:0]    grant_q, grant_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            ack_hit;
  logic            req_hit;
  logic [CW-1:0]   w_cur;

  // (a + b) mod N for a < N and b < N, without a general divider.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // First asserted request scanning ptr, ptr+1, ..., wrapping at N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_vld && req[wrap_add(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(ptr_q, k);
      end
    end
  end

  assign ack_hit = ack[idx_q];
  assign req_hit = req[idx_q];
  assign w_cur   = weight[idx_q*CW +: CW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d          = ST_GRANT;
          idx_d            = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        // ack wins over a simultaneous request drop.
        if (ack_hit) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          grant_d = '0;
          if (cnt_q == w_cur) begin
            ptr_d = wrap_add(idx_q, 1);
            cnt_d = '0;
          end else begin
            // Plain wrapping counter, so a lowered weight is caught after wrap.
            ptr_d = idx_q;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!req_hit) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          grant_d = '0;
          ptr_d   = wrap_add(idx_q, 1);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_weighted.sv
module tb_rr_arbiter_weighted;

  localparam int N  = 4;
  localparam int CW = 2;

  logic         clk;
  logic         rst_an;
  logic [3:0]   req, ack;
  logic [7:0]   weight;
  logic [3:0]   grant;
  logic [1:0]   grant_idx;
  logic         busy;

  logic [4:0]   req5, ack5;
  logic [9:0]   weight5;
  logic [4:0]   grant5;
  logic [2:0]   grant_idx5;
  logic         busy5;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: spec-level view of the arbiter
  int m_busy, m_idx, m_ptr, m_cnt;

  rr_arbiter_weighted #(.N(4), .CW(2)) dut (
    .clk(clk), .rst_an(rst_an), .req(req), .ack(ack), .weight(weight),
    .grant(grant), .grant_idx(grant_idx), .busy(busy)
  );

  rr_arbiter_weighted #(.N(5), .CW(2)) dut5 (
    .clk(clk), .rst_an(rst_an), .req(req5), .ack(ack5), .weight(weight5),
    .grant(grant5), .grant_idx(grant_idx5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Apply one clock edge's worth of the arbitration rules to the reference.
  task automatic model_step();
    int w;
    if (m_busy == 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_busy == 0 && req[(m_ptr + k) % N]) begin
          m_busy = 1;
          m_idx  = (m_ptr + k) % N;
        end
      end
    end else begin
      w = int'((weight >> (m_idx * CW)) & 8'h3);
      if (ack[m_idx]) begin
        if (m_cnt == w) begin
          m_ptr = (m_idx + 1) % N;
          m_cnt = 0;
        end else begin
          m_ptr = m_idx;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
        m_busy = 0;
      end else if (!req[m_idx]) begin
        m_ptr  = (m_idx + 1) % N;
        m_cnt  = 0;
        m_busy = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [3:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_busy != 0) ? 4'(1 << m_idx) : 4'd0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx), (m_busy != 0) ? 32'(m_idx) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    rst_an = 1'b0;
    #1;
    model_reset();
    #2;
    rst_an = 1'b1;
  endtask

  initial begin
    int seq27 [5];
    int seq28 [8];
    rst_an = 1'b1;
    req = '0; ack = '0; weight = '0;
    req5 = '0; ack5 = '0; weight5 = '0;
    seq27 = '{0, 1, 2, 3, 0};
    seq28 = '{0, 1, 1, 1, 0, 1, 1, 1};

    // reset state
    @(negedge clk);
    rst_an = 1'b0;
    #1;
    model_reset();
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.idx", 32'(grant_idx), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_an = 1'b1;

    // weights 0, all requesting, ack each grant
    req = 4'b1111; weight = '0;
    for (int i = 0; i < 5; i++) begin
      ack = '0;
      tick("rr0");
      chk("rr0.seq", 32'(grant), 32'(1 << seq27[i]));
      ack = 4'(1 << seq27[i]);
      tick("rr0.rel");
      chk("rr0.gap", 32'(grant), 32'd0);
    end
    ack = '0;

    // weight[1]=2, req 0011
    do_reset();
    req = 4'b0011; weight = 8'b00_00_10_00;
    for (int i = 0; i < 8; i++) begin
      ack = '0;
      tick("wgt");
      chk("wgt.seq", 32'(grant_idx), 32'(seq28[i]));
      ack = 4'(1 << seq28[i]);
      tick("wgt.rel");
    end
    ack = '0; weight = '0;

    // abort, then wrap from ptr=3
    do_reset();
    req = 4'b0100;
    tick("abt.g");
    chk("abt.g2", 32'(grant), 32'h4);
    req = 4'b0000;
    tick("abt.drop");
    chk("abt.drop0", 32'(grant), 32'd0);
    req = 4'b0111;
    tick("abt.wrap");
    chk("abt.wrap0", 32'(grant), 32'h1);
    ack = 4'b0001;
    tick("abt.rel");
    ack = '0;

    // foreign acks ignored, own ack releases and moves ptr to 2
    do_reset();
    req = 4'b0010;
    tick("fa.g");
    ack = 4'b1101;
    tick("fa.hold");
    chk("fa.hold1", 32'(grant), 32'h2);
    ack = 4'b0010;
    tick("fa.rel");
    chk("fa.rel0", 32'(grant), 32'd0);
    ack = '0; req = 4'b1111;
    tick("fa.ptr");
    chk("fa.ptr2", 32'(grant), 32'h4);
    req = '0;
    tick("fa.abort");

    // ack together with request drop counts as ack (cnt advances with weight)
    do_reset();
    weight = 8'b00_00_00_01;
    req = 4'b0001;
    tick("ad.g");
    req = 4'b0000; ack = 4'b0001;
    tick("ad.rel");
    req = 4'b1111; ack = '0;
    tick("ad.again");
    chk("ad.stay0", 32'(grant), 32'h1);
    ack = 4'b0001;
    tick("ad.rel2");
    ack = '0; weight = '0; req = '0;
    tick("ad.idle");

    // reset asserted mid-grant
    req = 4'b0100;
    tick("mr.g");
    chk("mr.g2", 32'(grant), 32'h4);
    #2;
    rst_an = 1'b0;
    #1;
    model_reset();
    chk("mr.grant", 32'(grant), 32'd0);
    chk("mr.busy", 32'(busy), 32'd0);
    chk("mr.idx", 32'(grant_idx), 32'd0);
    #1;
    rst_an = 1'b1;
    req = 4'b1111;
    tick("mr.after");
    chk("mr.after0", 32'(grant), 32'h1);
    ack = 4'b0001;
    tick("mr.rel");
    ack = '0;

    // randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom_range(0, 15));
      ack = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) weight = 8'($urandom);
      tick("rand");
    end
    req = '0; ack = '0;
    tick("rand.end");

    // N=5: wrap from 4 to 0
    req5 = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      ack5 = '0;
      @(posedge clk);
      #1;
      chk("n5.idx", 32'(grant_idx5), 32'(i % 5));
      chk("n5.grant", 32'(grant5), 32'(1 << (i % 5)));
      ack5 = 5'(1 << (i % 5));
      @(posedge clk);
      #1;
      chk("n5.gap", 32'(grant5), 32'd0);
    end
    ack5 = '0; req5 = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
